// File: rtl/telemetry_rx.sv
// telemetry_rx: UART receiver and frame parser for the e-bike telemetry link.
// Optional macro TELEM_RX_STRICT_EN rejects non-zero upper nibbles in high bytes.
module telemetry_rx #(
   parameter int unsigned BAUD_DIV     = 2604,
   parameter int unsigned TIMEOUT_BITS = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic [11:0] batt_v,
   output logic [11:0] avg_curr,
   output logic [11:0] avg_torque,
   output logic        pkt_vld,
   output logic        frm_err
);

   localparam int unsigned CW   = $clog2(BAUD_DIV);
   localparam int unsigned TLIM = TIMEOUT_BITS * BAUD_DIV;
   localparam int unsigned GW   = $clog2(TLIM + 1);
   localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
   localparam logic [GW-1:0] GLIM = GW'(TLIM);

   typedef enum logic [2:0] {
      U_IDLE, U_START, U_DATA, U_STOP, U_HOLD
   } ust_t;

   typedef enum logic [2:0] {
      P_HUNT_AA, P_HUNT_55, P_BH, P_BL, P_CH, P_CL, P_TH, P_TL
   } pst_t;

   logic          rx_m, rx_s;
   ust_t          ust;
   logic [CW-1:0] cnt;
   logic [2:0]    bitn;
   logic [7:0]    shreg;
   logic          byte_rdy;
   logic          stop_err;

   pst_t          ps;
   logic [3:0]    b_hi, c_hi, t_hi;
   logic [7:0]    b_lo, c_lo;
   logic [GW-1:0] gap;
   logic          tmo;
   logic          hi_state;
   logic          nib_bad;
   logic          nib_abort;
   logic          nib_err;
   logic          abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= RX;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ust      <= U_IDLE;
         cnt      <= '0;
         bitn     <= '0;
         shreg    <= '0;
         byte_rdy <= 1'b0;
         stop_err <= 1'b0;
      end else begin
         byte_rdy <= 1'b0;
         stop_err <= 1'b0;
         unique case (ust)
            U_IDLE: begin
               cnt <= '0;
               if (!rx_s) ust <= U_START;
            end
            U_START: begin
               if (cnt == HALF) begin
                  cnt  <= '0;
                  bitn <= '0;
                  ust  <= rx_s ? U_IDLE : U_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            U_DATA: begin
               if (cnt == FULL) begin
                  cnt   <= '0;
                  shreg <= {rx_s, shreg[7:1]};
                  bitn  <= bitn + 1'b1;
                  if (bitn == 3'd7) ust <= U_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            U_STOP: begin
               if (cnt == FULL) begin
                  cnt <= '0;
                  if (rx_s) begin
                     byte_rdy <= 1'b1;
                     ust      <= U_IDLE;
                  end else begin
                     stop_err <= 1'b1;
                     ust      <= U_HOLD;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            U_HOLD: begin
               if (rx_s) ust <= U_IDLE;
            end
            default: ust <= U_IDLE;
         endcase
      end
   end

   // Inter-byte gap only accumulates while a frame is open and the line is idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap <= '0;
      end else if (ps == P_HUNT_AA || byte_rdy || tmo) begin
         gap <= '0;
      end else if (ust == U_IDLE) begin
         gap <= gap + 1'b1;
      end
   end

   assign tmo      = (gap == GLIM);
   assign hi_state = (ps == P_BH) || (ps == P_CH) || (ps == P_TH);

`ifdef TELEM_RX_STRICT_EN
   assign nib_bad = |shreg[7:4];
`else
   assign nib_bad = 1'b0;
`endif

   assign nib_abort = byte_rdy & hi_state & nib_bad;
   assign abort     = stop_err | tmo | nib_abort;
   assign frm_err   = stop_err | nib_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps         <= P_HUNT_AA;
         b_hi       <= '0;
         b_lo       <= '0;
         c_hi       <= '0;
         c_lo       <= '0;
         t_hi       <= '0;
         batt_v     <= '0;
         avg_curr   <= '0;
         avg_torque <= '0;
         pkt_vld    <= 1'b0;
         nib_err    <= 1'b0;
      end else begin
         pkt_vld <= 1'b0;
         nib_err <= nib_abort;
         if (abort) begin
            ps   <= P_HUNT_AA;
            b_hi <= '0;
            b_lo <= '0;
            c_hi <= '0;
            c_lo <= '0;
            t_hi <= '0;
         end else if (byte_rdy) begin
            unique case (ps)
               P_HUNT_AA: if (shreg == 8'hAA) ps <= P_HUNT_55;
               P_HUNT_55: begin
                  if (shreg == 8'h55) ps <= P_BH;
                  else if (shreg != 8'hAA) ps <= P_HUNT_AA;
               end
               P_BH: begin b_hi <= shreg[3:0]; ps <= P_BL; end
               P_BL: begin b_lo <= shreg;      ps <= P_CH; end
               P_CH: begin c_hi <= shreg[3:0]; ps <= P_CL; end
               P_CL: begin c_lo <= shreg;      ps <= P_TH; end
               P_TH: begin t_hi <= shreg[3:0]; ps <= P_TL; end
               P_TL: begin
                  batt_v     <= {b_hi, b_lo};
                  avg_curr   <= {c_hi, c_lo};
                  avg_torque <= {t_hi, shreg};
                  pkt_vld    <= 1'b1;
                  ps         <= P_HUNT_AA;
               end
               default: ps <= P_HUNT_AA;
            endcase
         end
      end
   end

endmodule
